// File: rtl/parking_pkg.sv
// Shared FSM encoding and default sizing for the parking time tracker.
package parking_pkg;

   localparam int unsigned DEF_TIME_W = 8;
   localparam int unsigned DEF_SLOTS  = 4;
   localparam int unsigned DEF_RATE_W = 4;
   localparam int unsigned DEF_FEE_W  = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/parking_duration.sv
// Wrap-around elapsed time: (time_out - time_in) mod 2^W.
module parking_duration #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] time_out,
   input  logic [W-1:0] time_in,
   output logic [W-1:0] duration
);

   assign duration = time_out - time_in;

endmodule

// File: rtl/parking_time_tracker.sv
// Per-slot entry timestamps with an exit -> duration -> fee result pipeline.
module parking_time_tracker
   import parking_pkg::*;
#(
   parameter int unsigned TIME_W = DEF_TIME_W,
   parameter int unsigned SLOTS  = DEF_SLOTS,
   parameter int unsigned RATE_W = DEF_RATE_W,
   parameter int unsigned FEE_W  = DEF_FEE_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       tick,
   input  logic [RATE_W-1:0]          rate,
   input  logic                       entry_valid,
   input  logic [$clog2(SLOTS)-1:0]   entry_slot,
   input  logic                       exit_valid,
   input  logic [$clog2(SLOTS)-1:0]   exit_slot,
   output logic                       exit_ready,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [$clog2(SLOTS)-1:0]   res_slot,
   output logic [TIME_W-1:0]          res_duration,
   output logic [FEE_W-1:0]           res_fee,
   output logic [TIME_W-1:0]          cur_time,
   output logic [SLOTS-1:0]           occupied,
   output logic                       err
);

   localparam int unsigned SLOT_W = $clog2(SLOTS);
   localparam int unsigned PROD_W = TIME_W + RATE_W + FEE_W;
   localparam logic [FEE_W-1:0] FEE_MAX = '1;

   state_t              state_q;
   state_t              state_d;
   logic [TIME_W-1:0]   time_in [SLOTS];
   logic [TIME_W-1:0]   duration_c;
   logic [PROD_W-1:0]   prod_c;
   logic [FEE_W-1:0]    fee_c;
   logic                exit_fire;
   logic                exit_hit;
   logic                exit_err;
   logic                entry_ok;
   logic                entry_err;
   logic                exit_ready_d;
   logic                res_valid_d;
   logic                err_d;

   parking_duration #(.W(TIME_W)) u_duration (
      .time_out (cur_time),
      .time_in  (time_in[exit_slot]),
      .duration (duration_c)
   );

   // Product is widened past FEE_W so overflow is visible before saturating.
   assign prod_c = PROD_W'(res_duration) * PROD_W'(rate);
   assign fee_c  = (prod_c > PROD_W'(FEE_MAX)) ? FEE_MAX : FEE_W'(prod_c);

   // An entry to a slot being exited this cycle re-occupies it instead of erroring.
   always_comb begin
      exit_fire = exit_valid && exit_ready;
      exit_hit  = exit_fire && occupied[exit_slot];
      exit_err  = exit_fire && !occupied[exit_slot];
      entry_ok  = entry_valid &&
                  (!occupied[entry_slot] || (exit_hit && (exit_slot == entry_slot)));
      entry_err = entry_valid && !entry_ok;
   end

   always_comb begin
      state_d      = state_q;
      exit_ready_d = 1'b0;
      res_valid_d  = 1'b0;
      err_d        = entry_err || exit_err;
      case (state_q)
         IDLE:    if (exit_hit) state_d = CALC;
         CALC:    state_d = DONE;
         DONE:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      exit_ready_d = (state_d == IDLE);
      res_valid_d  = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         exit_ready <= 1'b1;
         res_valid  <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_d;
         exit_ready <= exit_ready_d;
         res_valid  <= res_valid_d;
         err        <= err_d;
      end
   end

   // Result payload: slot/duration latched on exit acceptance, fee in CALC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_slot     <= '0;
         res_duration <= '0;
         res_fee      <= '0;
      end else begin
         if (exit_hit) begin
            res_slot     <= exit_slot;
            res_duration <= duration_c;
         end
         if (state_q == CALC) res_fee <= fee_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_time <= '0;
         occupied <= '0;
         for (int i = 0; i < int'(SLOTS); i++) time_in[i] <= '0;
      end else begin
         if (tick) cur_time <= cur_time + TIME_W'(1);
         if (exit_hit) occupied[exit_slot] <= 1'b0;
         if (entry_ok) begin
            occupied[entry_slot] <= 1'b1;
            time_in[entry_slot]  <= cur_time;
         end
      end
   end

   logic [SLOT_W-1:0] unused_w;
   assign unused_w = '0;

endmodule
